// File: rtl/uncache_pkg.sv
// uncache_pkg: shared read-FSM states and the default write-buffer entry layout
package uncache_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_WB, RD, RESP} rd_state_t;
  localparam int UC_ADDR_WD = 32;
  localparam int UC_DATA_WD = 32;
  typedef struct packed {
    logic [UC_ADDR_WD-1:0]   addr;
    logic [UC_DATA_WD-1:0]   data;
    logic [UC_DATA_WD/8-1:0] strb;
  } wbuf_entry_t;
endpackage

// File: rtl/uncache_wfifo.sv
// uncache_wfifo: in-order store FIFO with full/empty and a word-address hazard match
module uncache_wfifo #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int DEPTH = 4,
  localparam int STRB_WD = DATA_WD / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ADDR_WD-1:0] in_addr,
  input  logic [DATA_WD-1:0] in_data,
  input  logic [STRB_WD-1:0] in_strb,
  input  logic               pop,
  output logic [ADDR_WD-1:0] out_addr,
  output logic [DATA_WD-1:0] out_data,
  output logic [STRB_WD-1:0] out_strb,
  output logic               full,
  output logic               empty,
  input  logic [ADDR_WD-3:0] match_word,
  output logic               match_any
);
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic [ADDR_WD-1:0] addr;
    logic [DATA_WD-1:0] data;
    logic [STRB_WD-1:0] strb;
  } entry_t;
  entry_t mem [DEPTH];
  logic [DEPTH-1:0] vld, hit;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic do_push, do_pop;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign {out_addr, out_data, out_strb} = mem[rd_ptr];
  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    assign hit[g] = vld[g] & (mem[g].addr[ADDR_WD-1:2] == match_word);
  end
  assign match_any = |hit;
  // entry storage, written at the tail; no reset needed since vld gates every use
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= '{addr: in_addr, data: in_data, strb: in_strb};
  end
  // pointers wrap naturally at DEPTH; vld tracks live slots for the match
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      vld <= '0;
    end else begin
      if (do_pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uncache_wbuf.sv
// uncache_wbuf: posted-store write buffer plus blocking single-beat uncached loads
module uncache_wbuf
  import uncache_pkg::*;
#(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int WBUF_DEPTH = 4,
  parameter int STRICT_ORDER = 1,
  localparam int STRB_WD = DATA_WD / 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic               stallreq,
  input  logic               conf_en,
  input  logic [STRB_WD-1:0] conf_wen,
  input  logic [ADDR_WD-1:0] conf_addr,
  input  logic [DATA_WD-1:0] conf_wdata,
  output logic [DATA_WD-1:0] conf_rdata,
  output logic               rd_req,
  output logic [ADDR_WD-1:0] rd_addr,
  input  logic [DATA_WD-1:0] rd_data,
  input  logic               rd_done,
  output logic               wr_req,
  output logic [STRB_WD-1:0] wr_wstrb,
  output logic [ADDR_WD-1:0] wr_addr,
  output logic [DATA_WD-1:0] wr_data,
  input  logic               wr_done,
  output logic               wbuf_empty
);
  rd_state_t state, state_nx;
  logic st, ld, full, empty, match_any, haz;
  logic [ADDR_WD-1:0] addr_q, head_addr, match_addr;
  logic [DATA_WD-1:0] head_data;
  logic [STRB_WD-1:0] head_strb;
  assign st = conf_en & |conf_wen;
  assign ld = conf_en & ~|conf_wen;
  assign match_addr = state == IDLE ? conf_addr : addr_q;
  assign haz = STRICT_ORDER != 0 ? ~empty : match_any;
  assign stallreq = (st & full) | (state == IDLE ? ld : state != RESP);
  assign wr_req = ~empty;
  assign wr_addr = empty ? '0 : head_addr;
  assign wr_data = empty ? '0 : head_data;
  assign wr_wstrb = empty ? '0 : head_strb;
  assign wbuf_empty = empty;
  assign rd_req = state == RD;
  assign rd_addr = addr_q;
  uncache_wfifo #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .DEPTH(WBUF_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(st),
    .in_addr(conf_addr),
    .in_data(conf_wdata),
    .in_strb(conf_wen),
    .pop(wr_done & wr_req),
    .out_addr(head_addr),
    .out_data(head_data),
    .out_strb(head_strb),
    .full(full),
    .empty(empty),
    .match_word(match_addr[ADDR_WD-1:2]),
    .match_any(match_any)
  );
  // load sequencing: wait out the write hazard, issue one read, release the pipe for a cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = ld ? (haz ? WAIT_WB : RD) : IDLE;
      WAIT_WB: state_nx = haz ? WAIT_WB : RD;
      RD:      state_nx = rd_done ? RESP : RD;
      default: state_nx = IDLE;
    endcase
  end
  // state, captured load address and returned load data
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      conf_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && ld) addr_q <= conf_addr;
      if (state == RD && rd_done) conf_rdata <= rd_data;
    end
  end
endmodule

// File: tb/tb_uncache_wbuf.sv
// tb_uncache_wbuf: directed checks of a strict-order and a relaxed-order instance
module tb_uncache_wbuf;
  logic clk = 1'b0;
  logic rst, conf_en, rd_done, wr_done;
  logic [3:0] conf_wen;
  logic [31:0] conf_addr, conf_wdata, rd_data;
  logic stallreq_s, rd_req_s, wr_req_s, wbuf_empty_s;
  logic stallreq_r, rd_req_r, wr_req_r, wbuf_empty_r;
  logic [31:0] conf_rdata_s, rd_addr_s, wr_addr_s, wr_data_s;
  logic [31:0] conf_rdata_r, rd_addr_r, wr_addr_r, wr_data_r;
  logic [3:0] wr_wstrb_s, wr_wstrb_r;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uncache_wbuf #(.STRICT_ORDER(1)) u_s (
    .clk(clk), .rst(rst), .stallreq(stallreq_s), .conf_en(conf_en), .conf_wen(conf_wen),
    .conf_addr(conf_addr), .conf_wdata(conf_wdata), .conf_rdata(conf_rdata_s),
    .rd_req(rd_req_s), .rd_addr(rd_addr_s), .rd_data(rd_data), .rd_done(rd_done),
    .wr_req(wr_req_s), .wr_wstrb(wr_wstrb_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .wr_done(wr_done), .wbuf_empty(wbuf_empty_s)
  );
  uncache_wbuf #(.STRICT_ORDER(0)) u_r (
    .clk(clk), .rst(rst), .stallreq(stallreq_r), .conf_en(conf_en), .conf_wen(conf_wen),
    .conf_addr(conf_addr), .conf_wdata(conf_wdata), .conf_rdata(conf_rdata_r),
    .rd_req(rd_req_r), .rd_addr(rd_addr_r), .rd_data(rd_data), .rd_done(rd_done),
    .wr_req(wr_req_r), .wr_wstrb(wr_wstrb_r), .wr_addr(wr_addr_r), .wr_data(wr_data_r),
    .wr_done(wr_done), .wbuf_empty(wbuf_empty_r)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    conf_en = 1'b0;
    conf_wen = 4'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    conf_en = 1'b1;
    conf_wen = 4'hf;
    conf_addr = a;
    conf_wdata = d;
  endtask

  task automatic load(input logic [31:0] a);
    conf_en = 1'b1;
    conf_wen = 4'h0;
    conf_addr = a;
  endtask

  task automatic reset_dut;
    rst = 1'b1;
    idle();
    conf_addr = '0;
    conf_wdata = '0;
    rd_data = '0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    reset_dut();
    checks++; if (stallreq_s !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stallreq_s); end
    checks++; if (rd_req_s !== 1'b0) begin failures++; $display("FAIL reset_rd_req got=%0h exp=0", rd_req_s); end
    checks++; if (wr_req_s !== 1'b0) begin failures++; $display("FAIL reset_wr_req got=%0h exp=0", wr_req_s); end
    checks++; if (rd_addr_s !== 32'h0) begin failures++; $display("FAIL reset_rd_addr got=%0h exp=0", rd_addr_s); end
    checks++; if ({wr_addr_s, wr_data_s, wr_wstrb_s} !== 68'h0) begin failures++; $display("FAIL reset_wr_bus got=%0h/%0h/%0h exp=0", wr_addr_s, wr_data_s, wr_wstrb_s); end
    checks++; if (conf_rdata_s !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", conf_rdata_s); end
    checks++; if (wbuf_empty_s !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0h exp=1", wbuf_empty_s); end
    checks++; if ({stallreq_r, rd_req_r, wr_req_r, wbuf_empty_r} !== 4'b0001) begin failures++; $display("FAIL reset_relaxed got=%b exp=0001", {stallreq_r, rd_req_r, wr_req_r, wbuf_empty_r}); end
  endtask

  task automatic test_fill;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      store(32'h1faf_f000 + 32'(4 * i), 32'h1000 + 32'(i));
      #1;
      checks++; if (stallreq_s !== 1'b0) begin failures++; $display("FAIL fill_nostall%0d got=%0h exp=0", i, stallreq_s); end
      cyc();
    end
    store(32'h1faf_f010, 32'h1004);
    #1;
    checks++; if (stallreq_s !== 1'b1) begin failures++; $display("FAIL fill_full_stall got=%0h exp=1", stallreq_s); end
    checks++; if (wr_addr_s !== 32'h1faf_f000) begin failures++; $display("FAIL fill_head0 got=%0h exp=1faff000", wr_addr_s); end
    wr_done = 1'b1;
    #1;
    checks++; if (stallreq_s !== 1'b1) begin failures++; $display("FAIL fill_pop_same_cycle got=%0h exp=1", stallreq_s); end
    cyc();
    wr_done = 1'b0;
    #1;
    checks++; if (stallreq_s !== 1'b0) begin failures++; $display("FAIL fill_unstall got=%0h exp=0", stallreq_s); end
    checks++; if (wr_addr_s !== 32'h1faf_f004) begin failures++; $display("FAIL fill_head1 got=%0h exp=1faff004", wr_addr_s); end
    cyc();
    idle();
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++; if (wr_req_s !== 1'b1 || wr_addr_s !== 32'h1faf_f000 + 32'(4 * k) || wr_data_s !== 32'h1000 + 32'(k)) begin
        failures++; $display("FAIL fill_drain%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, wr_req_s, wr_addr_s, wr_data_s, 32'h1faf_f000 + 32'(4 * k), 32'h1000 + 32'(k));
      end
      wr_done = 1'b1;
      cyc();
      wr_done = 1'b0;
    end
    #1;
    checks++; if (wbuf_empty_s !== 1'b1 || wr_req_s !== 1'b0) begin failures++; $display("FAIL fill_drained got=%0h/%0h exp=1/0", wbuf_empty_s, wr_req_s); end
  endtask

  task automatic test_strict;
    reset_dut();
    store(32'h1faf_f000, 32'h11);
    cyc();
    store(32'h1faf_f004, 32'h22);
    cyc();
    load(32'h1faf_f020);
    #1;
    checks++; if (stallreq_s !== 1'b1) begin failures++; $display("FAIL strict_load_stall got=%0h exp=1", stallreq_s); end
    cyc();
    checks++; if (rd_req_s !== 1'b0 || wr_req_s !== 1'b1) begin failures++; $display("FAIL strict_wait0 got=%0h/%0h exp=0/1", rd_req_s, wr_req_s); end
    wr_done = 1'b1;
    cyc();
    wr_done = 1'b0;
    #1;
    checks++; if (rd_req_s !== 1'b0) begin failures++; $display("FAIL strict_wait1 got=%0h exp=0", rd_req_s); end
    wr_done = 1'b1;
    cyc();
    wr_done = 1'b0;
    #1;
    checks++; if (rd_req_s !== 1'b0 || wbuf_empty_s !== 1'b1) begin failures++; $display("FAIL strict_wait2 got=%0h/%0h exp=0/1", rd_req_s, wbuf_empty_s); end
    cyc();
    checks++; if (rd_req_s !== 1'b1 || rd_addr_s !== 32'h1faf_f020 || wr_req_s !== 1'b0 || stallreq_s !== 1'b1) begin
      failures++; $display("FAIL strict_rd got=%0h/%0h/%0h/%0h exp=1/1faff020/0/1", rd_req_s, rd_addr_s, wr_req_s, stallreq_s);
    end
    rd_data = 32'hdead_beef;
    rd_done = 1'b1;
    #1;
    checks++; if (stallreq_s !== 1'b1) begin failures++; $display("FAIL strict_done_stall got=%0h exp=1", stallreq_s); end
    cyc();
    rd_done = 1'b0;
    rd_data = 32'h0;
    #1;
    checks++; if (stallreq_s !== 1'b0 || rd_req_s !== 1'b0 || conf_rdata_s !== 32'hdead_beef) begin
      failures++; $display("FAIL strict_resp got=%0h/%0h/%0h exp=0/0/deadbeef", stallreq_s, rd_req_s, conf_rdata_s);
    end
    cyc();
    idle();
    cyc();
    checks++; if (conf_rdata_s !== 32'hdead_beef || stallreq_s !== 1'b0) begin failures++; $display("FAIL strict_hold got=%0h/%0h exp=deadbeef/0", conf_rdata_s, stallreq_s); end
  endtask

  task automatic test_relaxed;
    reset_dut();
    store(32'h1faf_f010, 32'h55);
    cyc();
    load(32'h1faf_f020);
    #1;
    checks++; if (stallreq_r !== 1'b1 || rd_req_r !== 1'b0) begin failures++; $display("FAIL relax_req_cycle got=%0h/%0h exp=1/0", stallreq_r, rd_req_r); end
    cyc();
    checks++; if (rd_req_r !== 1'b1 || wr_req_r !== 1'b1 || rd_addr_r !== 32'h1faf_f020) begin
      failures++; $display("FAIL relax_concurrent got=%0h/%0h/%0h exp=1/1/1faff020", rd_req_r, wr_req_r, rd_addr_r);
    end
    rd_data = 32'h1234_5678;
    rd_done = 1'b1;
    cyc();
    rd_done = 1'b0;
    #1;
    checks++; if (stallreq_r !== 1'b0 || conf_rdata_r !== 32'h1234_5678) begin failures++; $display("FAIL relax_resp got=%0h/%0h exp=0/12345678", stallreq_r, conf_rdata_r); end
    cyc();
    load(32'h1faf_f012);
    #1;
    checks++; if (stallreq_r !== 1'b1) begin failures++; $display("FAIL relax_hz_stall got=%0h exp=1", stallreq_r); end
    cyc();
    checks++; if (rd_req_r !== 1'b0 || wr_req_r !== 1'b1) begin failures++; $display("FAIL relax_hz_wait0 got=%0h/%0h exp=0/1", rd_req_r, wr_req_r); end
    cyc();
    checks++; if (rd_req_r !== 1'b0) begin failures++; $display("FAIL relax_hz_wait1 got=%0h exp=0", rd_req_r); end
    wr_done = 1'b1;
    cyc();
    wr_done = 1'b0;
    #1;
    checks++; if (rd_req_r !== 1'b0 || wbuf_empty_r !== 1'b1) begin failures++; $display("FAIL relax_hz_wait2 got=%0h/%0h exp=0/1", rd_req_r, wbuf_empty_r); end
    cyc();
    checks++; if (rd_req_r !== 1'b1 || rd_addr_r !== 32'h1faf_f012) begin failures++; $display("FAIL relax_hz_rd got=%0h/%0h exp=1/1faff012", rd_req_r, rd_addr_r); end
    rd_data = 32'hcafe_f00d;
    rd_done = 1'b1;
    cyc();
    rd_done = 1'b0;
    #1;
    checks++; if (conf_rdata_r !== 32'hcafe_f00d || stallreq_r !== 1'b0) begin failures++; $display("FAIL relax_hz_resp got=%0h/%0h exp=cafef00d/0", conf_rdata_r, stallreq_r); end
    cyc();
    idle();
  endtask

  task automatic test_push_pop;
    reset_dut();
    store(32'h1faf_f040, 32'ha0);
    cyc();
    store(32'h1faf_f044, 32'ha1);
    cyc();
    store(32'h1faf_f048, 32'ha2);
    wr_done = 1'b1;
    #1;
    checks++; if (stallreq_s !== 1'b0 || wr_addr_s !== 32'h1faf_f040) begin failures++; $display("FAIL pp_same got=%0h/%0h exp=0/1faff040", stallreq_s, wr_addr_s); end
    cyc();
    wr_done = 1'b0;
    idle();
    #1;
    checks++; if (wr_addr_s !== 32'h1faf_f044 || wbuf_empty_s !== 1'b0) begin failures++; $display("FAIL pp_cnt2 got=%0h/%0h exp=1faff044/0", wr_addr_s, wbuf_empty_s); end
    wr_done = 1'b1;
    cyc();
    wr_done = 1'b0;
    #1;
    checks++; if (wr_addr_s !== 32'h1faf_f048 || wr_data_s !== 32'ha2 || wbuf_empty_s !== 1'b0) begin
      failures++; $display("FAIL pp_cnt1 got=%0h/%0h/%0h exp=1faff048/a2/0", wr_addr_s, wr_data_s, wbuf_empty_s);
    end
    wr_done = 1'b1;
    cyc();
    wr_done = 1'b0;
    #1;
    checks++; if (wbuf_empty_s !== 1'b1 || wr_req_s !== 1'b0) begin failures++; $display("FAIL pp_cnt0 got=%0h/%0h exp=1/0", wbuf_empty_s, wr_req_s); end
  endtask

  task automatic test_wrap;
    logic [31:0] qa[$];
    logic [3:0] qs[$];
    logic [31:0] a;
    logic [3:0] s;
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      a = 32'h1faf_f100 + 32'(4 * i);
      s = (i % 2 == 1) ? 4'h3 : 4'hf;
      conf_en = 1'b1;
      conf_wen = s;
      conf_addr = a;
      conf_wdata = a ^ 32'h5a5a_5a5a;
      wr_done = i >= 2;
      #1;
      checks++; if (stallreq_s !== 1'b0) begin failures++; $display("FAIL wrap_stall%0d got=%0h exp=0", i, stallreq_s); end
      if (wr_done) begin
        checks++; if (wr_addr_s !== qa[0] || wr_wstrb_s !== qs[0] || wr_data_s !== (qa[0] ^ 32'h5a5a_5a5a)) begin
          failures++; $display("FAIL wrap_pop%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", i, wr_addr_s, wr_wstrb_s, wr_data_s, qa[0], qs[0], qa[0] ^ 32'h5a5a_5a5a);
        end
        void'(qa.pop_front());
        void'(qs.pop_front());
      end
      qa.push_back(a);
      qs.push_back(s);
      cyc();
    end
    wr_done = 1'b0;
    idle();
    for (int k = 0; k < 8 && qa.size() > 0; k++) begin
      #1;
      checks++; if (wr_req_s !== 1'b1 || wr_addr_s !== qa[0] || wr_wstrb_s !== qs[0]) begin
        failures++; $display("FAIL wrap_drain%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, wr_req_s, wr_addr_s, wr_wstrb_s, qa[0], qs[0]);
      end
      void'(qa.pop_front());
      void'(qs.pop_front());
      wr_done = 1'b1;
      cyc();
      wr_done = 1'b0;
    end
    #1;
    checks++; if (wbuf_empty_s !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%0h exp=1", wbuf_empty_s); end
  endtask

  task automatic test_reset_mid;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      store(32'h1faf_f000 + 32'(4 * i), 32'h77 + 32'(i));
      cyc();
    end
    load(32'h1faf_f020);
    cyc();
    checks++; if (rd_req_r !== 1'b1 || wr_req_r !== 1'b1) begin failures++; $display("FAIL mid_rd got=%0h/%0h exp=1/1", rd_req_r, wr_req_r); end
    rst = 1'b1;
    idle();
    cyc();
    checks++; if (rd_req_r !== 1'b0 || wr_req_r !== 1'b0 || wbuf_empty_r !== 1'b1 || stallreq_r !== 1'b0) begin
      failures++; $display("FAIL mid_rst got=%0h/%0h/%0h/%0h exp=0/0/1/0", rd_req_r, wr_req_r, wbuf_empty_r, stallreq_r);
    end
    checks++; if (wr_req_s !== 1'b0 || wbuf_empty_s !== 1'b1) begin failures++; $display("FAIL mid_rst_strict got=%0h/%0h exp=0/1", wr_req_s, wbuf_empty_s); end
    rst = 1'b0;
    rd_data = 32'hbad0_bad0;
    rd_done = 1'b1;
    wr_done = 1'b1;
    cyc();
    rd_done = 1'b0;
    wr_done = 1'b0;
    #1;
    checks++; if (conf_rdata_r !== 32'h0 || rd_req_r !== 1'b0 || wbuf_empty_r !== 1'b1) begin
      failures++; $display("FAIL mid_late_done got=%0h/%0h/%0h exp=0/0/1", conf_rdata_r, rd_req_r, wbuf_empty_r);
    end
    checks++; if (conf_rdata_s !== 32'h0) begin failures++; $display("FAIL mid_late_strict got=%0h exp=0", conf_rdata_s); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_strict();
    test_relaxed();
    test_push_pop();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
